// File: rtl/syscall_responder.sv
// syscall_responder: services EX-stage SYSCALLs (display hex/dec, halt, pause); optional SYSCALL_DECIMAL_EN adds BCD conversion
//   Ports: clk, rst_n (async, active low), syscall_en, data_v0/data_a0 (service code/argument),
//   resume (board level) -> stall (comb), halt, display_data, display_valid (1-cycle pulse), syscall_count (wraps).
module syscall_responder #(
  parameter int          COUNT_WIDTH = 16,
  parameter logic [31:0] HEX_CODE    = 32'd34,
  parameter logic [31:0] DEC_CODE    = 32'd1,
  parameter logic [31:0] HALT_CODE   = 32'd10,
  parameter logic [31:0] PAUSE_CODE  = 32'd50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   syscall_en,
  input  logic [31:0]            data_v0,
  input  logic [31:0]            data_a0,
  input  logic                   resume,
  output logic                   stall,
  output logic                   halt,
  output logic [31:0]            display_data,
  output logic                   display_valid,
  output logic [COUNT_WIDTH-1:0] syscall_count
);
  typedef enum logic [2:0] {
    IDLE,
    EXEC,
`ifdef SYSCALL_DECIMAL_EN
    CONVERT,
`endif
    PAUSED,
    HALTED
  } state_t;
  state_t                 state_q, state_d;
  logic [31:0]            v0_q, v0_d, a0_q, a0_d, data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   valid_q, valid_d, resume_q;
`ifdef SYSCALL_DECIMAL_EN
  logic [31:0]            bcd_q, bcd_d, bcd_adj;
  logic [4:0]             bit_q, bit_d;
`endif
  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    a0_d    = a0_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = 1'b0;
`ifdef SYSCALL_DECIMAL_EN
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++)
      bcd_adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
`endif
    case (state_q)
      IDLE: if (syscall_en) begin
        v0_d    = data_v0;
        a0_d    = data_a0;
        count_d = count_q + 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = IDLE;
        if (v0_q == HALT_CODE) state_d = HALTED;
        else if (v0_q == PAUSE_CODE) state_d = PAUSED;
`ifdef SYSCALL_DECIMAL_EN
        else if (v0_q == DEC_CODE) begin
          state_d = CONVERT;
          bcd_d   = '0;
          bit_d   = '0;
        end
        else if (v0_q == HEX_CODE) begin
`else
        else if (v0_q == HEX_CODE || v0_q == DEC_CODE) begin
`endif
          data_d  = a0_q;
          valid_d = 1'b1;
        end
      end
`ifdef SYSCALL_DECIMAL_EN
      // Only 8 digits are displayed, so the digit overflow recirculates into the spent binary shifter.
      CONVERT: begin
        bcd_d = {bcd_adj[30:0], a0_q[31]};
        a0_d  = {a0_q[30:0], bcd_adj[31]};
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          state_d = IDLE;
          data_d  = bcd_d;
          valid_d = 1'b1;
        end
      end
`endif
      PAUSED: if (resume && !resume_q) state_d = IDLE;
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      v0_q     <= '0;
      a0_q     <= '0;
      data_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      resume_q <= 1'b0;
`ifdef SYSCALL_DECIMAL_EN
      bcd_q    <= '0;
      bit_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      v0_q     <= v0_d;
      a0_q     <= a0_d;
      data_q   <= data_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      resume_q <= resume;
`ifdef SYSCALL_DECIMAL_EN
      bcd_q    <= bcd_d;
      bit_q    <= bit_d;
`endif
    end
  end
  assign stall         = (syscall_en && state_q == IDLE) || state_q != IDLE;
  assign halt          = state_q == PAUSED || state_q == HALTED;
  assign display_data  = data_q;
  assign display_valid = valid_q;
  assign syscall_count = count_q;
endmodule
